// File: rtl/test_status_port_if.sv
// Store-path and status bus between the microISA-16 core side and the
// test status peripheral. The core/testbench side uses master and the
// peripheral uses slave.
interface test_status_port_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        status_valid;
  logic [1:0]  status_level;
  logic [13:0] status_code;
  logic        timeout;
  logic        status_done;

  modport master (
    output wr_en, wr_addr, wr_data, console_ready,
    input  wr_ready, console_valid, console_data,
    input  status_valid, status_level, status_code, timeout, status_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, console_ready,
    output wr_ready, console_valid, console_data,
    output status_valid, status_level, status_code, timeout, status_done
  );
endinterface

// File: rtl/test_status_port.sv
// Write-only test status peripheral: console byte FIFO, status reporting
// and a hardware watchdog. Once a final status (FATAL/SUCCESS or watchdog
// expiry) is latched, the block waits for the console FIFO to drain and
// then raises a sticky status_done.
module test_status_port #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst_n,
  test_status_port_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] ADDR_CONSOLE = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ;

  logic        wd_en;
  logic [15:0] wd_count, wd_count_next;

  logic is_run, full, empty, accept, push, pop;
  logic wd_clear, expire, status_wr, final_status;

  logic        status_valid_r, timeout_r;
  logic [1:0]  status_level_r;
  logic [13:0] status_code_r;

  // Decode of the accepted store and the watchdog next count for this cycle.
  always_comb begin
    is_run        = (state == ST_RUN);
    full          = (occ == DEPTH_C);
    empty         = (occ == '0);
    // Only a console store into a full FIFO is back-pressured; after the
    // final status everything is swallowed so the core cannot deadlock.
    bus.wr_ready  = !(is_run && (bus.wr_addr == ADDR_CONSOLE) && full);
    accept        = bus.wr_en && bus.wr_ready;
    push          = is_run && accept && (bus.wr_addr == ADDR_CONSOLE);
    pop           = !empty && bus.console_ready;
    // Both KICK (2) and CTRL (3) clear the counter; they share addr bit 1.
    wd_clear      = is_run && accept && bus.wr_addr[1];
    wd_count_next = wd_count;
    if (wd_clear) begin
      wd_count_next = '0;
    end else if (wd_en) begin
      wd_count_next = wd_count + 16'd1;
    end
    expire        = is_run && wd_en && !wd_clear && (wd_count_next == TIMEOUT_C);
    // Expiry owns the status outputs; a coincident STATUS store is dropped.
    status_wr     = is_run && accept && (bus.wr_addr == ADDR_STATUS) && !expire;
    final_status  = status_wr && bus.wr_data[15];
  end

  // Next-state logic: RUN until a final status, DRAIN until the FIFO empties.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (expire || final_status) state_next = ST_DRAIN;
      ST_DRAIN: if (empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data[7:0];
  end

  // Watchdog enable and counter, frozen once the block leaves RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_en    <= 1'b0;
      wd_count <= '0;
    end else if (is_run) begin
      wd_count <= wd_count_next;
      if (accept && (bus.wr_addr == ADDR_CTRL)) wd_en <= bus.wr_data[0];
    end
  end

  // Status pulse, held level/code and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_valid_r <= 1'b0;
      status_level_r <= 2'd0;
      status_code_r  <= 14'd0;
      timeout_r      <= 1'b0;
    end else begin
      status_valid_r <= 1'b0;
      if (expire) begin
        status_valid_r <= 1'b1;
        status_level_r <= 2'd1;
        status_code_r  <= 14'h3FFF;
        timeout_r      <= 1'b1;
      end else if (status_wr) begin
        status_valid_r <= 1'b1;
        status_level_r <= bus.wr_data[15:14];
        status_code_r  <= bus.wr_data[13:0];
      end
    end
  end

  assign bus.console_valid = !empty;
  assign bus.console_data  = empty ? 8'd0 : mem[rd_ptr];
  assign bus.status_valid  = status_valid_r;
  assign bus.status_level  = status_level_r;
  assign bus.status_code   = status_code_r;
  assign bus.timeout       = timeout_r;
  assign bus.status_done   = (state == ST_DONE);
endmodule

// File: tb/tb_test_status_port.sv
// Bench for test_status_port: directed scenarios plus a randomized phase,
// checked each cycle against a queue-based reference model.
module tb_test_status_port;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  test_status_port_if bus();

  test_status_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit          m_run    = 1'b1;
  bit          m_done   = 1'b0;
  bit          m_tmo    = 1'b0;
  bit          m_wd_en  = 1'b0;
  int          m_occ    = 0;
  int          clr_cyc  = 0;
  logic [7:0]  cq[$];
  logic [15:0] sq[$];
  logic [1:0]  last_level = 2'd0;
  logic [13:0] last_code  = 14'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: applies the rules of the peripheral at each rising edge.
  initial begin : model_p
    bit acc, clr, expd, pu, po;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_run = 1'b1; m_done = 1'b0; m_tmo = 1'b0; m_wd_en = 1'b0;
        m_occ = 0; clr_cyc = cyc;
        cq.delete(); sq.delete();
        last_level = 2'd0; last_code = 14'd0;
      end else begin
        if (!m_run && m_occ == 0) m_done = 1'b1;
        po = (m_occ != 0) && bus.console_ready;
        pu = 1'b0;
        if (m_run) begin
          acc  = bus.wr_en && !(bus.wr_addr == 2'd0 && m_occ == DEPTH);
          clr  = acc && (bus.wr_addr >= 2'd2);
          expd = m_wd_en && !clr && (cyc - clr_cyc == TMO);
          if (acc) begin
            case (bus.wr_addr)
              2'd0: begin cq.push_back(bus.wr_data[7:0]); pu = 1'b1; end
              2'd1: if (!expd) begin
                      sq.push_back(bus.wr_data);
                      if (bus.wr_data[15:14] >= 2'd2) m_run = 1'b0;
                    end
              2'd2: clr_cyc = cyc;
              default: begin clr_cyc = cyc; m_wd_en = bus.wr_data[0]; end
            endcase
          end
          if (expd) begin
            sq.push_back({2'd1, 14'h3FFF});
            m_tmo = 1'b1;
            m_run = 1'b0;
          end
        end
        m_occ = m_occ + int'(pu) - int'(po);
      end
    end
  end

  // Monitor: compares every output on the falling edge against the model.
  initial begin : monitor_p
    bit exp_pulse;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("wr_ready", bus.wr_ready, !(m_run && bus.wr_addr == 2'd0 && m_occ == DEPTH));
        chk("console_valid", bus.console_valid, cq.size() != 0);
        if (bus.console_valid) begin
          if (cq.size() != 0) begin
            chk("console_data", bus.console_data, cq[0]);
            if (bus.console_ready) void'(cq.pop_front());
          end
        end else begin
          chk("console_data_idle", bus.console_data, 32'd0);
        end
        exp_pulse = (sq.size() != 0);
        chk("status_valid", bus.status_valid, exp_pulse);
        if (exp_pulse) begin
          e = sq.pop_front();
          last_level = e[15:14];
          last_code  = e[13:0];
        end
        chk("status_level", bus.status_level, last_level);
        chk("status_code", bus.status_code, last_code);
        chk("timeout", bus.timeout, m_tmo);
        chk("status_done", bus.status_done, m_done);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL write_accept: got no wr_ready expected acceptance within 200 cycles (addr %0d)", a);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  bit rnd_done;

  initial begin : stim_p
    logic [15:0] d;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 16'd0;
    bus.console_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(1);
    rst_n = 1'b1;

    // Idle with watchdog disabled: nothing may happen.
    idle(2000);

    // "Hi" back-to-back with the consumer ready.
    wr(2'd0, 16'h0048);
    wr(2'd0, 16'h0069);
    idle(5);

    // Overfill the FIFO; one pop frees the slot for the stalled 9th byte.
    bus.console_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) wr(2'd0, 16'($urandom));
      end
      begin
        idle(15);
        bus.console_ready = 1'b1;
        idle(1);
        bus.console_ready = 1'b0;
      end
    join
    idle(3);
    bus.console_ready = 1'b1;
    idle(15);

    // Randomized console traffic and INFO/ERROR statuses with a jittery consumer.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          d = 16'($urandom);
          if ($urandom_range(0, 3) != 0) begin
            wr(2'd0, d);
          end else begin
            d[15] = 1'b0;
            wr(2'd1, d);
          end
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !rnd_done; c++) begin
          bus.console_ready = 1'($urandom);
          idle(1);
        end
      end
    join
    bus.console_ready = 1'b1;
    idle(20);

    // SUCCESS with bytes pending: done only after the drain.
    bus.console_ready = 1'b0;
    wr(2'd0, 16'h0031);
    wr(2'd0, 16'h0032);
    wr(2'd0, 16'h0033);
    wr(2'd1, 16'hC005);
    idle(5);
    bus.console_ready = 1'b1;
    idle(10);
    wr(2'd1, 16'h4001);
    wr(2'd0, 16'h0041);
    idle(5);

    // Watchdog with two kicks, then expiry.
    do_reset(2);
    wr(2'd3, 16'h0001);
    idle(498);
    wr(2'd2, 16'h0000);
    idle(898);
    wr(2'd2, 16'hFFFF);
    idle(1100);

    // Kick landing on the would-be expiry cycle, then reset while draining.
    do_reset(2);
    wr(2'd3, 16'h0001);
    idle(999);
    wr(2'd2, 16'h0000);
    idle(600);
    bus.console_ready = 1'b0;
    wr(2'd0, 16'h0011);
    wr(2'd0, 16'h0022);
    wr(2'd1, 16'h8007);
    idle(3);
    do_reset(1);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/test_status_port.md
Name: test_status_port

Overview:
- DUT-side counterpart of the testbench logging/watchdog utilities.
- Write-only memory-mapped peripheral on the microISA-16 core's store path. Software running on the core uses it to:
  - emit console characters,
  - report INFO/ERROR/FATAL/SUCCESS status codes,
  - kick a hardware watchdog.
- The testbench reads the console stream and status outputs. It ends simulation on status_done, which asserts only after every queued console byte has drained.

Parameters:
- FIFO_DEPTH, 8, console FIFO entries (power of two, >=2)
- TIMEOUT_CYCLES, 1000, watchdog limit in clk cycles (>=2, fits 16 bits)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- wr_en  input  1  core store request
- wr_addr  input  2  register select: 0 CONSOLE, 1 STATUS, 2 WDOG_KICK, 3 WDOG_CTRL
- wr_data  input  16  store data
- wr_ready  output  1  store accepted when wr_en && wr_ready
- console_valid  output  1  console byte available
- console_data  output  8  console byte, head of FIFO
- console_ready  input  1  testbench consumes byte when console_valid && console_ready
- status_valid  output  1  one-cycle pulse per accepted STATUS write or timeout
- status_level  output  2  0 INFO, 1 ERROR, 2 FATAL, 3 SUCCESS
- status_code  output  14  code accompanying status_level
- timeout  output  1  sticky watchdog expiry flag
- status_done  output  1  sticky; final status reported and console drained

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - state RUN, FIFO empty, console_valid=0, console_data=0
  - status_valid=0, status_level=0, status_code=0
  - timeout=0, status_done=0, watchdog disabled, counter=0
  - Reset mid-operation discards FIFO contents and any pending state.
- States:
  - RUN: normal operation.
  - DRAIN: final status latched; waiting for FIFO empty.
  - DONE: terminal until reset.
- wr_ready:
  - In RUN: 0 only when wr_addr==0 and FIFO full.
  - In DRAIN/DONE: always 1; all writes are accepted and ignored, so the core never deadlocks.
- CONSOLE (addr 0, RUN):
  - Pushes wr_data[7:0]; upper bits ignored.
  - Byte is visible on console_valid the next cycle. There is no combinational bypass.
  - FIFO is first-in first-out. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when not full: both occur, occupancy unchanged.
  - When full, the push is stalled, even if a pop happens in the same cycle.
  - Pop when console_valid=0 has no effect.
- STATUS (addr 1, RUN):
  - Next cycle: status_level=wr_data[15:14], status_code=wr_data[13:0], status_valid=1 for exactly one cycle.
  - Level INFO/ERROR: stay in RUN.
  - Level FATAL/SUCCESS: go to DRAIN.
  - status_level and status_code hold their last value after the pulse.
- WDOG_CTRL (addr 3, RUN): enable <= wr_data[0]; counter cleared.
- WDOG_KICK (addr 2, RUN): counter cleared; wr_data ignored.
- Watchdog (RUN only):
  - Enabled and no clear in the cycle: count_next = count + 1.
  - Clear in the cycle: count_next = 0. A kick therefore always beats expiry in the same cycle.
  - When count_next == TIMEOUT_CYCLES:
    - timeout=1
    - status_level=ERROR, status_code=14'h3FFF
    - status_valid pulse
    - go to DRAIN
  - A STATUS write in that same cycle is ignored.
  - Counter frozen in DRAIN/DONE.
- DRAIN: FIFO keeps popping via console_ready. When the FIFO is empty, go to DONE. If it is already empty on entry, DONE follows one cycle after entry.
- DONE: status_done=1 (registered), sticky until reset.
- Watchdog disabled: counter holds at 0 and timeout can never fire.

Test Plan:
- Reset then idle with console_ready=1 → all outputs 0; status_done stays 0 for 2000 cycles (watchdog disabled).
- Write CONSOLE 'H','i' (0x48, 0x69) back-to-back with console_ready=1 → console_data 0x48 then 0x69 on consecutive cycles, first one cycle after the first write; console_valid then drops.
- console_ready=0; write 9 CONSOLE bytes (depth 8) → wr_ready=0 on the 9th. Raise console_ready for one cycle → 9th byte accepted the following cycle; order preserved across the pointer wrap.
- Queue 3 bytes with console_ready=0, then STATUS 0xC005 → status_valid pulse, level=3, code=5; status_done stays 0. Raise console_ready → status_done=1 one cycle after the last byte pops. A subsequent STATUS write is accepted but outputs are unchanged.
- Enable watchdog (CTRL=1); kick at cycles 500 and 1400; no further kicks → no timeout before cycle 2400. At count 1000 after the last kick: timeout=1, level=1, code=0x3FFF, status_done=1 (FIFO empty).
- Kick in the exact cycle count_next would reach 1000 → no timeout. Assert rst_n=0 mid-DRAIN → all outputs and state return to reset values next cycle.
